// File: rtl/tour_monitor.sv
// Knight's-tour monitor: tracks settled squares on a WxH board and
// flags off-board, illegal, revisit and timeout errors.
module tour_monitor #(
  parameter int BOARD_W = 5,
  parameter int BOARD_H = 5,
  parameter int COORD_W = 3,
  parameter int TIMEOUT_CLKS = 2_000_000,
  localparam int CNT_W = $clog2(BOARD_W*BOARD_H+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [COORD_W-1:0]         start_xx,
  input  logic [COORD_W-1:0]         start_yy,
  input  logic                       pos_vld,
  input  logic [COORD_W-1:0]         xx,
  input  logic [COORD_W-1:0]         yy,
  input  logic                       clr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic [CNT_W-1:0]           move_cnt,
  output logic [BOARD_W*BOARD_H-1:0] visited
);

  localparam int N     = BOARD_W*BOARD_H;
  localparam int IDX_W = $clog2(N);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS+1);
  localparam int DW    = COORD_W+1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       vis_q, vis_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [DW-1:0]    dx, dy;
  logic [IDX_W-1:0] tgt_idx, st_idx;
  logic [N-1:0]     tgt_mask, st_mask;
  logic [CNT_W-1:0] cnt_inc;
  logic             on_board, st_on_board;
  logic             legal, hit;

  // Move geometry against the last accepted square
  always_comb begin
    dx = ({1'b0, xx} >= {1'b0, px_q})
       ? {1'b0, xx} - {1'b0, px_q}
       : {1'b0, px_q} - {1'b0, xx};
    dy = ({1'b0, yy} >= {1'b0, py_q})
       ? {1'b0, yy} - {1'b0, py_q}
       : {1'b0, py_q} - {1'b0, yy};
    legal = (dx == DW'(1) && dy == DW'(2))
         || (dx == DW'(2) && dy == DW'(1));
    on_board = (32'(xx) < BOARD_W)
            && (32'(yy) < BOARD_H);
    st_on_board = (32'(start_xx) < BOARD_W)
               && (32'(start_yy) < BOARD_H);
    tgt_idx = IDX_W'(32'(yy) * BOARD_W + 32'(xx));
    st_idx  = IDX_W'(32'(start_yy) * BOARD_W
                     + 32'(start_xx));
    tgt_mask = N'(1) << tgt_idx;
    st_mask  = N'(1) << st_idx;
    hit      = |(vis_q & tgt_mask);
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;
    px_d    = px_q;
    py_d    = py_q;
    wd_d    = wd_q;
    if (clr) begin
      state_d = S_IDLE;
      code_d  = 3'd0;
      cnt_d   = '0;
      vis_d   = '0;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !st_on_board) begin
            state_d = S_ERR;
            code_d  = 3'd1;
            cnt_d   = '0;
          end else if (start) begin
            state_d = S_TRACK;
            vis_d   = st_mask;
            cnt_d   = CNT_W'(1);
            px_d    = start_xx;
            py_d    = start_yy;
            wd_d    = '0;
          end
        end
        S_TRACK: begin
          if (pos_vld) begin
            unique case (1'b1)
              !on_board: begin
                state_d = S_ERR;
                code_d  = 3'd1;
              end
              on_board && !legal: begin
                state_d = S_ERR;
                code_d  = 3'd2;
              end
              on_board && legal && hit: begin
                state_d = S_ERR;
                code_d  = 3'd3;
              end
              default: begin
                vis_d = vis_q | tgt_mask;
                cnt_d = cnt_inc;
                px_d  = xx;
                py_d  = yy;
                wd_d  = '0;
                if (cnt_inc == CNT_W'(N))
                  state_d = S_DONE;
              end
            endcase
          end else if (wd_q == WD_W'(TIMEOUT_CLKS-1)) begin
            state_d = S_ERR;
            code_d  = 3'd4;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
      cnt_q   <= '0;
      vis_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
      px_q    <= px_d;
      py_q    <= py_d;
      wd_q    <= wd_d;
    end
  end

  assign busy     = (state_q == S_TRACK);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign err_code = code_q;
  assign move_cnt = cnt_q;
  assign visited  = vis_q;

endmodule

// File: tb/tb_tour_monitor.sv
// Bench for tour_monitor: 5x5 and 8x8 instances checked against
// a square-set reference model of the tour rules.
module tb_tour_monitor;

  localparam int T = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] start_xx = '0, start_yy = '0;
  logic pos_vld = 1'b0;
  logic [2:0] xx = '0, yy = '0;
  logic clr = 1'b0;

  logic b5, d5, e5;
  logic [2:0] code5;
  logic [4:0] cnt5;
  logic [24:0] vis5;
  logic b8, d8, e8;
  logic [2:0] code8;
  logic [6:0] cnt8;
  logic [63:0] vis8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tour_monitor #(.BOARD_W(5), .BOARD_H(5), .COORD_W(3),
                 .TIMEOUT_CLKS(T)) u5 (
    .clk(clk), .rst(rst), .start(start),
    .start_xx(start_xx), .start_yy(start_yy),
    .pos_vld(pos_vld), .xx(xx), .yy(yy), .clr(clr),
    .busy(b5), .done(d5), .err(e5), .err_code(code5),
    .move_cnt(cnt5), .visited(vis5));

  tour_monitor #(.BOARD_W(8), .BOARD_H(8), .COORD_W(3),
                 .TIMEOUT_CLKS(T)) u8 (
    .clk(clk), .rst(rst), .start(start),
    .start_xx(start_xx), .start_yy(start_yy),
    .pos_vld(pos_vld), .xx(xx), .yy(yy), .clr(clr),
    .busy(b8), .done(d8), .err(e8), .err_code(code8),
    .move_cnt(cnt8), .visited(vis8));

  // Reference model of the 5x5 monitor
  bit m_busy, m_done, m_err;
  logic [2:0] m_code;
  logic [4:0] m_cnt;
  logic [24:0] m_vis;
  int m_px, m_py, m_since;

  int tour_x[25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,
                     1,3,4,2,0,1,3,4,3,1,0,2};
  int tour_y[25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,
                     0,1,3,4,3,1,0,2,4,3,1,2};
  int kdx[8] = '{1,2,2,1,-1,-2,-2,-1};
  int kdy[8] = '{2,1,-1,-2,-2,-1,1,2};

  function automatic logic [35:0] obs5();
    return {b5, d5, e5, code5, cnt5, vis5};
  endfunction

  function automatic logic [35:0] exp5();
    return {m_busy, m_done, m_err, m_code, m_cnt, m_vis};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0;
    m_code = 0; m_cnt = 0; m_vis = 0;
    m_px = 0; m_py = 0; m_since = 0;
  endtask

  task automatic model_fail(int c);
    m_busy = 0;
    m_err  = 1;
    m_code = 3'(c);
  endtask

  task automatic model_edge(bit st, int sx, int sy,
                            bit pv, int x, int y, bit c);
    int ax, ay;
    if (c) begin
      m_busy = 0; m_done = 0; m_err = 0;
      m_code = 0; m_cnt = 0; m_vis = 0;
    end else if (!m_busy && !m_done && !m_err) begin
      if (st) begin
        if (sx >= 5 || sy >= 5) begin
          model_fail(1);
          m_cnt = 0;
        end else begin
          m_vis = 0;
          m_vis[sy*5+sx] = 1'b1;
          m_cnt = 1;
          m_px = sx; m_py = sy;
          m_since = 0;
          m_busy = 1;
        end
      end
    end else if (m_busy) begin
      if (pv) begin
        ax = (x > m_px) ? x - m_px : m_px - x;
        ay = (y > m_py) ? y - m_py : m_py - y;
        if (x >= 5 || y >= 5) model_fail(1);
        else if (ax * ay != 2) model_fail(2);
        else if (m_vis[y*5+x]) model_fail(3);
        else begin
          m_vis[y*5+x] = 1'b1;
          m_cnt = m_cnt + 5'd1;
          m_px = x; m_py = y;
          m_since = 0;
          if (m_cnt == 5'd25) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else begin
        m_since++;
        if (m_since == T) model_fail(4);
      end
    end
  endtask

  task automatic step(bit st, int sx, int sy,
                      bit pv, int x, int y, bit c);
    start = st; start_xx = 3'(sx); start_yy = 3'(sy);
    pos_vld = pv; xx = 3'(x); yy = 3'(y); clr = c;
    @(posedge clk);
    #1;
    start = 0; pos_vld = 0; clr = 0;
    model_edge(st, sx, sy, pv, x, y, c);
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (obs5() !== 36'd0) begin
      errors++;
      $display("FAIL reset5 got %h want 0", obs5());
    end
    checks++;
    if ({b8, d8, e8, code8, cnt8, vis8} !== 77'd0) begin
      errors++;
      $display("FAIL reset8 got cnt %0d vis %h", cnt8, vis8);
    end
    #9 rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_tour();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs5() !== exp5() || cnt5 !== 5'd1) begin
      errors++;
      $display("FAIL tour_start got %h want %h", obs5(), exp5());
    end
    for (int i = 1; i < 25; i++) begin
      step(0, 0, 0, 1, tour_x[i], tour_y[i], 0);
      checks++;
      if (obs5() !== exp5() || cnt5 !== 5'(i + 1)) begin
        errors++;
        $display("FAIL tour_move%0d got %h want %h",
                 i, obs5(), exp5());
      end
    end
    checks++;
    if (d5 !== 1'b1 || e5 !== 1'b0 || vis5 !== 25'h1FFFFFF) begin
      errors++;
      $display("FAIL tour_done got d=%b e=%b vis=%h want 1 0 1ffffff",
               d5, e5, vis5);
    end
    step(1, 1, 1, 1, 1, 2, 0);
    checks++;
    if (obs5() !== exp5()) begin
      errors++;
      $display("FAIL done_hold got %h want %h", obs5(), exp5());
    end
  endtask

  task automatic test_illegal();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    checks++;
    if (obs5() !== exp5() || code5 !== 3'd2 || cnt5 !== 5'd1
        || vis5 !== 25'h0000001) begin
      errors++;
      $display("FAIL illegal got %h want %h", obs5(), exp5());
    end
    step(0, 0, 0, 1, 2, 1, 0);
    checks++;
    if (obs5() !== exp5()) begin
      errors++;
      $display("FAIL err_hold got %h want %h", obs5(), exp5());
    end
  endtask

  task automatic test_revisit();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs5() !== exp5() || code5 !== 3'd3 || cnt5 !== 5'd2) begin
      errors++;
      $display("FAIL revisit got %h want %h", obs5(), exp5());
    end
  endtask

  task automatic test_off_board();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 3, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 3, 0);
    checks++;
    if (obs5() !== exp5() || code5 !== 3'd1 || cnt5 !== 5'd1) begin
      errors++;
      $display("FAIL off_move got %h want %h", obs5(), exp5());
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 7, 0, 0, 0, 0, 0);
    checks++;
    if (obs5() !== exp5() || e5 !== 1'b1 || code5 !== 3'd1
        || cnt5 !== 5'd0) begin
      errors++;
      $display("FAIL off_start got %h want %h", obs5(), exp5());
    end
  endtask

  task automatic test_timeout();
    int k;
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (e5 !== 1'b1 && k < 3 * T) begin
      step(0, 0, 0, 0, 0, 0, 0);
      k++;
    end
    checks++;
    if (k != T || code5 !== 3'd4 || obs5() !== exp5()) begin
      errors++;
      $display("FAIL timeout got %0d cycles code %0d want %0d code 4",
               k, code5, T);
    end
    step(0, 0, 0, 1, 1, 2, 1);
    checks++;
    if (obs5() !== 36'd0 || obs5() !== exp5()) begin
      errors++;
      $display("FAIL clr_prio got %h want 0", obs5());
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 7; i++)
      step(0, 0, 0, 1, tour_x[i], tour_y[i], 0);
    checks++;
    if (cnt5 !== 5'd7 || obs5() !== exp5()) begin
      errors++;
      $display("FAIL pre_rst got cnt %0d want 7", cnt5);
    end
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (obs5() !== 36'd0) begin
      errors++;
      $display("FAIL async_rst got %h want 0", obs5());
    end
    #2 rst = 0;
    @(posedge clk);
    #1;
    step(1, 2, 2, 0, 0, 0, 0);
    checks++;
    if (obs5() !== exp5() || vis5 !== 25'h0001000) begin
      errors++;
      $display("FAIL rst_restart got %h want %h", obs5(), exp5());
    end
    step(0, 0, 0, 1, 4, 3, 0);
    checks++;
    if (obs5() !== exp5() || cnt5 !== 5'd2) begin
      errors++;
      $display("FAIL rst_move got %h want %h", obs5(), exp5());
    end
  endtask

  task automatic test_board8();
    logic [63:0] want;
    want = (64'd1 << 62) | (64'd1 << 47);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 6, 7, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 5, 0);
    checks++;
    if (vis8 !== want || cnt8 !== 7'd2 || b8 !== 1'b1
        || e8 !== 1'b0) begin
      errors++;
      $display("FAIL board8 got vis %h cnt %0d want %h 2",
               vis8, cnt8, want);
    end
  endtask

  task automatic test_random();
    int x, y, d;
    bit pv, st, c;
    for (int it = 0; it < 30; it++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, $urandom_range(0, 5), $urandom_range(0, 5),
           0, 0, 0, 0);
      checks++;
      if (obs5() !== exp5()) begin
        errors++;
        $display("FAIL rnd_start%0d got %h want %h",
                 it, obs5(), exp5());
      end
      for (int j = 0; j < 24; j++) begin
        pv = ($urandom % 4) != 0;
        st = ($urandom % 8) == 0;
        c  = ($urandom % 50) == 0;
        if (($urandom % 10) < 8) begin
          d = $urandom % 8;
          x = m_px + kdx[d];
          y = m_py + kdy[d];
          if (x < 0 || x > 7) x = $urandom % 8;
          if (y < 0 || y > 7) y = $urandom % 8;
        end else begin
          x = $urandom % 8;
          y = $urandom % 8;
        end
        step(st, $urandom % 8, $urandom % 8, pv, x, y, c);
        checks++;
        if (obs5() !== exp5()) begin
          errors++;
          $display("FAIL rnd%0d_%0d got %h want %h",
                   it, j, obs5(), exp5());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_tour();
    test_illegal();
    test_revisit();
    test_off_board();
    test_timeout();
    test_async_reset();
    test_board8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
